// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-stage types and MEM/WB field widths.
package pipe_pkg;
    localparam int WB_W = 2;
    localparam int RW_W = 5;
    localparam int WORD_W = 32;
    localparam int MEMWB_DATA_W = WB_W + RW_W + 2 * WORD_W;
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE = 2'd1;
    localparam logic [1:0] OCC_TWO = 2'd2;
    typedef enum logic [1:0] {
        EMPTY = OCC_EMPTY,
        ONE   = OCC_ONE,
        TWO   = OCC_TWO
    } skid_state_t;
endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: saturating up-counter, falling-edge clocked, sync active-low reset.
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);
    // count up on i_inc, sticking at all-ones
    always_ff @(negedge i_clk) begin
        if (!i_reset)
            o_cnt <= '0;
        else if (i_inc && !(&o_cnt))
            o_cnt <= o_cnt + 1'b1;
    end
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic stage register with 2-entry skid; PIPE_SKID_STALL_CNT_EN adds a stall counter.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = MEMWB_DATA_W,
    parameter int CNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [1:0]        o_occupancy
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_stall_cnt
`endif
);
    skid_state_t r_state, w_state;
    logic [DATA_W-1:0] r_main, r_skid, w_main, w_skid;
    logic r_in_ready, r_out_valid;
    logic w_in_fire, w_out_fire;

    assign w_in_fire = i_in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & i_out_ready;
    assign o_in_ready = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data = r_main;
    assign o_occupancy = r_state;

    // next state and payload moves; flush empties both slots
    always_comb begin
        w_state = r_state;
        w_main = r_main;
        w_skid = r_skid;
        case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_state = ONE;
                    w_main = i_in_data;
                end
            end
            ONE: begin
                if (w_in_fire && w_out_fire)
                    w_main = i_in_data;
                else if (w_in_fire) begin
                    w_state = TWO;
                    w_skid = i_in_data;
                end else if (w_out_fire)
                    w_state = EMPTY;
            end
            TWO: begin
                if (w_out_fire) begin
                    w_state = ONE;
                    w_main = r_skid;
                    w_skid = '0;
                end
            end
            default: w_state = EMPTY;
        endcase
        if (i_flush) begin
            w_state = EMPTY;
            w_main = '0;
            w_skid = '0;
        end
    end

    // state, payload and handshake flags all registered so ready never depends on out_ready combinationally
    always_ff @(negedge i_clk) begin
        if (!i_reset) begin
            r_state <= EMPTY;
            r_main <= '0;
            r_skid <= '0;
            r_in_ready <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state;
            r_main <= w_main;
            r_skid <= w_skid;
            r_in_ready <= w_state != TWO;
            r_out_valid <= w_state != EMPTY;
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (r_out_valid & ~i_out_ready),
        .o_cnt   (o_stall_cnt)
    );
`endif
endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline stage register that supersedes fixed-field inter-stage latches such as MEM/WB. It carries an opaque payload with a valid/ready handshake, a two-entry skid buffer so that `in_ready` is a pure flop output, and a synchronous flush that inserts a bubble. It sits between any two pipeline stages, with the MEM→WB boundary as the first user, and lets downstream stalls propagate upstream without a combinational ready path.

## Interface
- `DATA_W`, default 71: payload width. 71 = 2 WB control + 5 Rw + 32 ALUout + 32 DataMem.
- `CNT_W`, default 16: stall counter width. Used only with the macro.
- `clk`, input, 1: stage clock. All state updates on the falling edge, matching the codebase stage registers.
- `reset`, input, 1: synchronous, active-low. Sampled on the `clk` falling edge.
- `flush`, input, 1: discard all held and incoming entries this cycle.
- `in_valid`, input, 1: upstream entry present.
- `in_ready`, output, 1: registered; this stage can accept an entry.
- `in_data`, input, DATA_W: upstream payload.
- `out_valid`, output, 1: registered; an entry is presented downstream.
- `out_ready`, input, 1: downstream accepts.
- `out_data`, output, DATA_W: registered payload, driven from the main register.
- `occupancy`, output, 2: number of entries held (0, 1 or 2).
- `stall_cnt`, output, CNT_W: present only with `PIPE_SKID_STALL_CNT_EN`.

## Operation
- Handshakes:
  - `in_fire = in_valid & in_ready`
  - `out_fire = out_valid & out_ready`
- Storage: main register (drives `out_data`) plus one skid register.
- States: EMPTY (occupancy 0), ONE (main valid), TWO (main and skid valid).
- EMPTY:
  - `in_fire` → ONE, main ← `in_data`.
  - Otherwise stay in EMPTY.
- ONE:
  - `in_fire & out_fire` → ONE, main ← `in_data`.
  - `in_fire & !out_ready` → TWO, skid ← `in_data`.
  - `!in_fire & out_fire` → EMPTY.
  - Otherwise hold.
- TWO:
  - `in_ready` is 0, so no input is accepted.
  - `out_fire` → ONE, main ← skid.
  - Otherwise hold.
- Decoded outputs:
  - `in_ready` = next state ≠ TWO.
  - `out_valid` = next state ≠ EMPTY.
  - Both are registered with the state.
- Flush has highest priority after reset:
  - Next state EMPTY; main and skid cleared to 0.
  - An entry handshaked in the flush cycle is dropped.
  - A downstream `out_fire` in the flush cycle still completes; the entry is consumed once.
- Order is strictly FIFO. No entry is duplicated or lost except by flush.
- Cleared payload is all zeros, so a flushed or reset WB control field reads as "no write".

## Timing
- Reset (`reset` = 0 at a falling edge):
  - state EMPTY
  - `in_ready` = 0, `out_valid` = 0
  - `out_data` = 0, skid = 0
  - `occupancy` = 0
  - `stall_cnt` = 0
- First falling edge with `reset` = 1 sets `in_ready` = 1. Inputs are ignored while reset is low.
- Latency: 1 clock from `in_fire` to `out_valid` when the stage was EMPTY or drained that edge.
- Throughput: 1 entry/cycle while `out_ready` is held high.
- Backpressure: `in_ready` falls one cycle after the first unaccepted output. This costs one skid slot, which absorbs the in-flight entry.
- Reset mid-operation discards both entries with no partial output.
- No combinational path from `out_ready` to `in_ready`.

## Configuration
- Macro: `PIPE_SKID_STALL_CNT_EN`.
- With the macro defined:
  - `stall_cnt` port exists.
  - Increments on each cycle with `out_valid & !out_ready`.
  - Saturates at 2^CNT_W−1.
  - Cleared by reset only, not by flush.
- Without the macro: port and counter are absent; the rest of the behaviour is identical.

## Structure
- Shared package `pipe_pkg`:
  - 2-bit state typedef (EMPTY/ONE/TWO).
  - Occupancy constants.
  - MEM/WB field widths: WB_W = 2, RW_W = 5, WORD_W = 32.
  - `MEMWB_DATA_W` = 71.
- Sub-module `pipe_sat_cnt` (saturating up-counter, CNT_W parameter, sync active-low reset). Instantiated only under the macro.

## Test plan
- Reset held 3 cycles with `in_valid` = 1 and `in_data` = 0x5A → `out_valid` = 0, `out_data` = 0, `in_ready` = 0; `in_ready` = 1 one edge after release.
- Stream 0x01..0x08 with `out_ready` = 1 → outputs 0x01..0x08 on consecutive cycles, 1-cycle latency, `occupancy` = 1 throughout.
- `out_ready` = 0 while sending 0x11 then 0x22 → `occupancy` = 2, `in_ready` = 0, `out_data` = 0x11. Raising `out_ready` emits 0x11 then 0x22.
- Flush in state TWO with `in_valid` = 1 (`in_data` = 0x33) → next cycle EMPTY, `out_data` = 0, 0x33 never emitted.
- Flush concurrent with `out_fire` of 0x44 → 0x44 consumed exactly once; stage EMPTY afterwards.
- With `PIPE_SKID_STALL_CNT_EN` and CNT_W = 2: hold `out_valid` = 1, `out_ready` = 0 for 5 cycles → `stall_cnt` = 3, holds 3 after flush, 0 after reset.
